// File: rtl/ptmch_spi_gen.sv
// SPI command frame generator: sends an 8-bit opcode, optionally followed by a 24-bit address, in SPI mode 0.
// Chip-select setup, hold and idle spacing are set by parameters.
//
// state | meaning
// IDLE  | ready for a command, SPI_CS high
// SETUP | SPI_CS low, first bit driven, waiting P_CS_SETUP cycles
// SHIFT | SPI_CLK toggling, one bit per 2*div cycles
// HOLD  | SPI_CS still low after the last falling edge
// GAP   | SPI_CS high, enforcing the inter-frame idle time
module ptmch_spi_gen #(
    parameter int P_CS_SETUP = 2,
    parameter int P_CS_HOLD  = 2,
    parameter int P_CS_IDLE  = 4
) (
    input  logic        RESET_N,
    input  logic        CLK100M,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [7:0]  CMD_OPCODE,
    input  logic [23:0] CMD_ADDR,
    input  logic        CMD_ADDR_EN,
    input  logic [7:0]  CLK_DIV,
    output logic        SPI_CS,
    output logic        SPI_CLK,
    output logic        SPI_MOSI,
    output logic        CMD_DONE,
    output logic        BUSY
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int SETUP_N = (P_CS_SETUP < 1) ? 1 : P_CS_SETUP;
    localparam int HOLD_N  = (P_CS_HOLD < 1) ? 1 : P_CS_HOLD;
    // The IDLE cycle in which the next command is accepted also has SPI_CS high,
    // so GAP lasts one cycle less than the required idle time.
    localparam int GAP_N   = (P_CS_IDLE < 2) ? 1 : P_CS_IDLE - 1;

    localparam logic [7:0] SETUP_LD = 8'(SETUP_N - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_N - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP_N - 1);

    logic [2:0]  state;
    logic [7:0]  tmr;
    logic [7:0]  half_cnt;
    logic [4:0]  bit_cnt;
    logic [31:0] sr;
    logic [7:0]  div_q;
    logic        clk_q;
    logic        done_q;
    logic        rdy_en;
    logic        cs_active;

    assign cs_active = (state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD);
    assign CMD_READY = rdy_en && (state == S_IDLE);
    assign BUSY      = (state != S_IDLE);
    assign SPI_CS    = ~cs_active;
    assign SPI_CLK   = clk_q;
    assign SPI_MOSI  = cs_active & sr[31];
    assign CMD_DONE  = done_q;

    always_ff @(posedge CLK100M or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            tmr      <= 8'd0;
            half_cnt <= 8'd0;
            bit_cnt  <= 5'd0;
            sr       <= 32'd0;
            div_q    <= 8'd1;
            clk_q    <= 1'b0;
            done_q   <= 1'b0;
            rdy_en   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (CMD_VALID && rdy_en) begin
                        state   <= S_SETUP;
                        tmr     <= SETUP_LD;
                        div_q   <= (CLK_DIV == 8'd0) ? 8'd1 : CLK_DIV;
                        sr      <= CMD_ADDR_EN ? {CMD_OPCODE, CMD_ADDR} : {CMD_OPCODE, 24'h000000};
                        bit_cnt <= CMD_ADDR_EN ? 5'd31 : 5'd7;
                    end
                end
                S_SETUP: begin
                    if (tmr == 8'd0) begin
                        state    <= S_SHIFT;
                        half_cnt <= div_q - 8'd1;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (half_cnt != 8'd0) begin
                        half_cnt <= half_cnt - 8'd1;
                    end else if (!clk_q) begin
                        clk_q    <= 1'b1;
                        half_cnt <= div_q - 8'd1;
                    end else begin
                        // Data advances only as SPI_CLK falls, keeping it stable across the rising edge.
                        clk_q    <= 1'b0;
                        half_cnt <= div_q - 8'd1;
                        if (bit_cnt == 5'd0) begin
                            state <= S_HOLD;
                            tmr   <= HOLD_LD;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                            sr      <= {sr[30:0], 1'b0};
                        end
                    end
                end
                S_HOLD: begin
                    if (tmr == 8'd0) begin
                        state  <= S_GAP;
                        done_q <= 1'b1;
                        tmr    <= GAP_LD;
                        sr     <= 32'd0;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                S_GAP: begin
                    if (tmr == 8'd0) begin
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptmch_spi_gen.sv
// Directed bench for ptmch_spi_gen: frame timing, serialized data, back-to-back spacing and reset abort.
module tb_ptmch_spi_gen;

    logic        RESET_N;
    logic        CLK100M;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [7:0]  CMD_OPCODE;
    logic [23:0] CMD_ADDR;
    logic        CMD_ADDR_EN;
    logic [7:0]  CLK_DIV;
    logic        SPI_CS;
    logic        SPI_CLK;
    logic        SPI_MOSI;
    logic        CMD_DONE;
    logic        BUSY;

    int vectors = 0;
    int errors  = 0;

    ptmch_spi_gen #(.P_CS_SETUP(2), .P_CS_HOLD(2), .P_CS_IDLE(4)) dut (
        .RESET_N    (RESET_N),
        .CLK100M    (CLK100M),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_OPCODE (CMD_OPCODE),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_ADDR_EN(CMD_ADDR_EN),
        .CLK_DIV    (CLK_DIV),
        .SPI_CS     (SPI_CS),
        .SPI_CLK    (SPI_CLK),
        .SPI_MOSI   (SPI_MOSI),
        .CMD_DONE   (CMD_DONE),
        .BUSY       (BUSY)
    );

    initial CLK100M = 1'b0;
    always #5 CLK100M = ~CLK100M;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command from IDLE and follows the frame to CMD_DONE.
    // Cycle count: the negedge before the accepting edge is 0, so CMD_DONE shows up at count 1+setup+N*2*div+hold.
    task automatic run_frame(input string tag, input logic [7:0] op, input logic [23:0] addr,
                             input logic en, input logic [7:0] div, input int exp_bits,
                             input logic [31:0] exp_word, input int exp_cyc, input bit perturb);
        int cyc;
        int pulses;
        logic [31:0] word;
        logic prev;
        bit cs_glitch;
        CMD_OPCODE  = op;
        CMD_ADDR    = addr;
        CMD_ADDR_EN = en;
        CLK_DIV     = div;
        CMD_VALID   = 1'b1;
        check({tag, "_ready"}, 32'(CMD_READY), 32'd1);
        @(negedge CLK100M);
        CMD_VALID = 1'b0;
        cyc = 1;
        check({tag, "_cs_latency"}, 32'(SPI_CS), 32'd0);
        check({tag, "_first_bit"}, 32'(SPI_MOSI), 32'(exp_word[exp_bits-1]));
        pulses = 0;
        word = 32'd0;
        prev = SPI_CLK;
        cs_glitch = 1'b0;
        while (!CMD_DONE && cyc < 1000) begin
            if (perturb && cyc == 10) begin
                CMD_OPCODE = ~op;
                CLK_DIV    = div + 8'd3;
                CMD_ADDR   = ~addr;
            end
            @(negedge CLK100M);
            cyc++;
            if (SPI_CLK && !prev) begin
                word = {word[30:0], SPI_MOSI};
                pulses++;
            end
            prev = SPI_CLK;
            if (!CMD_DONE && SPI_CS) cs_glitch = 1'b1;
        end
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_bits));
        check({tag, "_word"}, word, exp_word);
        check({tag, "_cs_held_low"}, 32'(cs_glitch), 32'd0);
        check({tag, "_gap_cs_clk_mosi"}, {29'd0, SPI_CS, SPI_CLK, SPI_MOSI}, 32'b100);
        @(negedge CLK100M);
        check({tag, "_done_one_cycle"}, 32'(CMD_DONE), 32'd0);
        cyc = 0;
        while (!CMD_READY && cyc < 50) begin
            @(negedge CLK100M);
            cyc++;
        end
        check({tag, "_back_to_ready"}, 32'(CMD_READY), 32'd1);
    endtask

    initial begin
        int cyc;
        int hi;
        int pulses;
        logic prev;
        bit done_seen;
        RESET_N     = 1'b0;
        CMD_VALID   = 1'b0;
        CMD_OPCODE  = 8'h00;
        CMD_ADDR    = 24'h0;
        CMD_ADDR_EN = 1'b0;
        CLK_DIV     = 8'd1;
        repeat (3) @(negedge CLK100M);
        check("rst_outputs", {26'd0, SPI_CS, SPI_CLK, SPI_MOSI, CMD_DONE, BUSY, CMD_READY}, 32'b100000);
        #1 RESET_N = 1'b1;
        #1 check("rst_ready_before_edge", 32'(CMD_READY), 32'd0);
        @(negedge CLK100M);
        check("rst_ready_after_edge", 32'(CMD_READY), 32'd1);

        run_frame("op0f_div1", 8'h0F, 24'h0, 1'b0, 8'd1, 8, 32'h0000000F, 21, 1'b0);
        run_frame("op10_addr_div2", 8'h10, 24'h00ABCD, 1'b1, 8'd2, 32, 32'h1000ABCD, 133, 1'b0);
        run_frame("div0_as_div1", 8'h0F, 24'h0, 1'b0, 8'd0, 8, 32'h0000000F, 21, 1'b0);
        run_frame("op81_div3", 8'h81, 24'hFFFFFF, 1'b0, 8'd3, 8, 32'h00000081, 53, 1'b0);
        run_frame("midframe_change", 8'hA5, 24'h123456, 1'b1, 8'd1, 32, 32'hA5123456, 69, 1'b1);

        // Back-to-back frames with CMD_VALID held high.
        CMD_OPCODE  = 8'h3C;
        CMD_ADDR_EN = 1'b0;
        CLK_DIV     = 8'd1;
        CMD_VALID   = 1'b1;
        @(negedge CLK100M);
        cyc = 0;
        while (!CMD_DONE && cyc < 100) begin
            @(negedge CLK100M);
            cyc++;
        end
        check("b2b_first_done", 32'(CMD_DONE), 32'd1);
        hi = 0;
        while (SPI_CS && hi < 50) begin
            @(negedge CLK100M);
            hi++;
        end
        CMD_VALID = 1'b0;
        check("b2b_cs_idle_cycles", 32'(hi), 32'd4);
        check("b2b_second_busy", 32'(BUSY), 32'd1);
        repeat (5) @(negedge CLK100M);
        CMD_VALID = 1'b1;
        repeat (2) @(negedge CLK100M);
        CMD_VALID = 1'b0;
        cyc = 0;
        while (!CMD_DONE && cyc < 100) begin
            @(negedge CLK100M);
            cyc++;
        end
        check("b2b_second_done", 32'(CMD_DONE), 32'd1);
        repeat (20) @(negedge CLK100M);
        check("busy_valid_not_queued", 32'(BUSY), 32'd0);

        // Reset during bit 12 of a 32-bit frame.
        CMD_OPCODE  = 8'h10;
        CMD_ADDR    = 24'h00ABCD;
        CMD_ADDR_EN = 1'b1;
        CLK_DIV     = 8'd1;
        CMD_VALID   = 1'b1;
        @(negedge CLK100M);
        CMD_VALID = 1'b0;
        pulses = 0;
        prev = SPI_CLK;
        cyc = 0;
        while (pulses < 12 && cyc < 200) begin
            @(negedge CLK100M);
            cyc++;
            if (SPI_CLK && !prev) pulses++;
            prev = SPI_CLK;
        end
        check("abort_reached_bit12", 32'(pulses), 32'd12);
        RESET_N = 1'b0;
        #1 check("abort_outputs_now", {26'd0, SPI_CS, SPI_CLK, SPI_MOSI, CMD_DONE, BUSY, CMD_READY}, 32'b100000);
        repeat (3) @(negedge CLK100M);
        check("abort_outputs_held", {26'd0, SPI_CS, SPI_CLK, SPI_MOSI, CMD_DONE, BUSY, CMD_READY}, 32'b100000);
        #1 RESET_N = 1'b1;
        @(negedge CLK100M);
        check("abort_ready_after_release", 32'(CMD_READY), 32'd1);
        done_seen = 1'b0;
        repeat (20) begin
            @(negedge CLK100M);
            if (CMD_DONE || !SPI_CS) done_seen = 1'b1;
        end
        check("abort_no_done_no_frame", 32'(done_seen), 32'd0);

        run_frame("after_abort", 8'hC3, 24'h0, 1'b0, 8'd1, 8, 32'h000000C3, 21, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
